dcache_assoc: RTL and testbench

//  Parametrised N-way set-associative, write-back, write-allocate data cache.

---
 rtl/dcache_assoc.sv | 255 +++++++++++++++++++++++++
 tb/tb_dcache_assoc.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_assoc.sv
// rtl/dcache_assoc.sv - N-way set-associative write-back, write-allocate data cache
// Zero-latency hits; misses burst whole lines over cbus; round-robin replacement; full flush.
module dcache_assoc #(
    parameter int WAYS       = 2,
    parameter int SETS       = 8,
    parameter int LINE_WORDS = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        dreq_valid_i,
    input  logic [31:0] dreq_addr_i,
    input  logic [2:0]  dreq_size_i,
    input  logic [7:0]  dreq_strobe_i,
    input  logic [63:0] dreq_data_i,
    output logic        dresp_addr_ok_o,
    output logic        dresp_data_ok_o,
    output logic [63:0] dresp_data_o,
    output logic        creq_valid_o,
    output logic        creq_is_write_o,
    output logic [31:0] creq_addr_o,
    output logic [2:0]  creq_size_o,
    output logic [3:0]  creq_len_o,
    output logic [1:0]  creq_burst_o,
    output logic [7:0]  creq_strobe_o,
    output logic [63:0] creq_data_o,
    input  logic        cresp_ready_i,
    input  logic        cresp_last_i,
    input  logic [63:0] cresp_data_i,
    input  logic        flush_req_i,
    output logic        flush_done_o,
    output logic [63:0] mem_o [WAYS*SETS*LINE_WORDS]
);
    localparam int OFF_W  = 3;
    localparam int WORD_W = $clog2(LINE_WORDS);
    localparam int IDX_W  = $clog2(SETS);
    localparam int TAG_W  = 32 - OFF_W - WORD_W - IDX_W;
    localparam int WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int LINES  = WAYS * SETS;
    localparam int LINE_W = $clog2(LINES);
    localparam int MEM_N  = LINES * LINE_WORDS;
    localparam int MEM_W  = $clog2(MEM_N);

    typedef enum logic [2:0] {IDLE, WRITEBACK, FETCH, FLUSH_SCAN, FLUSH_WB} state_t;

    state_t            state_q, state_d;
    logic [WORD_W-1:0] beat_q, beat_d;
    logic [WAY_W-1:0]  vway_q, vway_d;
    logic [IDX_W-1:0]  vset_q, vset_d;
    logic [TAG_W-1:0]  vtag_q, vtag_d;
    logic              full_q, full_d;
    logic [LINE_W-1:0] fidx_q, fidx_d;
    logic              fpend_q, fpend_d;

    logic [LINES-1:0]  valid_q, dirty_q;
    logic [TAG_W-1:0]  tag_q [LINES];
    logic [WAY_W-1:0]  vptr_q [SETS];
    logic [63:0]       mem_q [MEM_N];

    function automatic logic [LINE_W-1:0] line_of(input logic [WAY_W-1:0] w, input logic [IDX_W-1:0] s);
        return LINE_W'(int'(w) * SETS + int'(s));
    endfunction

    function automatic logic [MEM_W-1:0] mem_at(input logic [LINE_W-1:0] l, input logic [WORD_W-1:0] wd);
        return MEM_W'(int'(l) * LINE_WORDS + int'(wd));
    endfunction

    logic [WORD_W-1:0] req_word;
    logic [IDX_W-1:0]  req_set;
    logic [TAG_W-1:0]  req_tag;
    logic              hit, inv_found;
    logic [WAY_W-1:0]  hit_way, inv_way, vic_way;
    logic [LINE_W-1:0] hit_line, vic_line, cur_line;
    logic [MEM_W-1:0]  hit_idx, burst_idx;
    logic              hit_wr, fill_wr, fill_last, wb_last, scan_inv;
    logic              unused_ok;

    assign req_word  = dreq_addr_i[OFF_W +: WORD_W];
    assign req_set   = dreq_addr_i[OFF_W+WORD_W +: IDX_W];
    assign req_tag   = dreq_addr_i[31 -: TAG_W];
    assign unused_ok = ^{dreq_size_i, dreq_addr_i[OFF_W-1:0]};

    // Descending scan so the lowest-numbered invalid way wins.
    always_comb begin
        hit       = 1'b0;
        hit_way   = '0;
        inv_found = 1'b0;
        inv_way   = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (valid_q[line_of(WAY_W'(w), req_set)] && tag_q[line_of(WAY_W'(w), req_set)] == req_tag) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
            if (!valid_q[line_of(WAY_W'(w), req_set)]) begin
                inv_found = 1'b1;
                inv_way   = WAY_W'(w);
            end
        end
    end

    assign vic_way   = inv_found ? inv_way : vptr_q[req_set];
    assign vic_line  = line_of(vic_way, req_set);
    assign hit_line  = line_of(hit_way, req_set);
    assign hit_idx   = mem_at(hit_line, req_word);
    assign cur_line  = line_of(vway_q, vset_q);
    assign burst_idx = mem_at(cur_line, beat_q);

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        vway_d  = vway_q;
        vset_d  = vset_q;
        vtag_d  = vtag_q;
        full_d  = full_q;
        fidx_d  = fidx_q;
        fpend_d = fpend_q | flush_req_i;
        dresp_addr_ok_o = 1'b0;
        dresp_data_ok_o = 1'b0;
        dresp_data_o    = '0;
        creq_valid_o    = 1'b0;
        creq_is_write_o = 1'b0;
        creq_addr_o     = '0;
        creq_size_o     = '0;
        creq_len_o      = '0;
        creq_burst_o    = '0;
        creq_strobe_o   = '0;
        creq_data_o     = '0;
        flush_done_o    = 1'b0;
        hit_wr    = 1'b0;
        fill_wr   = 1'b0;
        fill_last = 1'b0;
        wb_last   = 1'b0;
        scan_inv  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (fpend_q || flush_req_i) begin
                    state_d = FLUSH_SCAN;
                    fidx_d  = '0;
                    fpend_d = 1'b0;
                end else if (dreq_valid_i) begin
                    if (hit) begin
                        dresp_addr_ok_o = 1'b1;
                        dresp_data_ok_o = 1'b1;
                        dresp_data_o    = mem_q[hit_idx];
                        hit_wr          = |dreq_strobe_i;
                    end else begin
                        vway_d  = vic_way;
                        vset_d  = req_set;
                        vtag_d  = req_tag;
                        full_d  = !inv_found;
                        beat_d  = '0;
                        state_d = (valid_q[vic_line] && dirty_q[vic_line]) ? WRITEBACK : FETCH;
                    end
                end
            end
            WRITEBACK, FLUSH_WB: begin
                creq_valid_o    = 1'b1;
                creq_is_write_o = 1'b1;
                creq_addr_o     = {tag_q[cur_line], vset_q, {(WORD_W+OFF_W){1'b0}}};
                creq_size_o     = 3'd3;
                creq_len_o      = 4'(LINE_WORDS - 1);
                creq_burst_o    = 2'd1;
                creq_strobe_o   = 8'hFF;
                creq_data_o     = mem_q[burst_idx];
                if (cresp_ready_i) begin
                    beat_d = beat_q + WORD_W'(1);
                    if (cresp_last_i) begin
                        beat_d  = '0;
                        wb_last = 1'b1;
                        state_d = (state_q == WRITEBACK) ? FETCH : FLUSH_SCAN;
                    end
                end
            end
            FETCH: begin
                creq_valid_o = 1'b1;
                creq_addr_o  = {vtag_q, vset_q, {(WORD_W+OFF_W){1'b0}}};
                creq_size_o  = 3'd3;
                creq_len_o   = 4'(LINE_WORDS - 1);
                creq_burst_o = 2'd1;
                if (cresp_ready_i) begin
                    fill_wr = 1'b1;
                    beat_d  = beat_q + WORD_W'(1);
                    if (cresp_last_i) begin
                        beat_d    = '0;
                        fill_last = 1'b1;
                        state_d   = IDLE;
                    end
                end
            end
            FLUSH_SCAN: begin
                // A written-back line is revisited once clean, then invalidated here.
                if (valid_q[fidx_q] && dirty_q[fidx_q]) begin
                    vway_d  = WAY_W'(int'(fidx_q) / SETS);
                    vset_d  = fidx_q[IDX_W-1:0];
                    beat_d  = '0;
                    state_d = FLUSH_WB;
                end else begin
                    scan_inv = 1'b1;
                    if (fidx_q == LINE_W'(LINES - 1)) begin
                        flush_done_o = 1'b1;
                        state_d      = IDLE;
                    end else begin
                        fidx_d = fidx_q + LINE_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            beat_q  <= '0;
            vway_q  <= '0;
            vset_q  <= '0;
            vtag_q  <= '0;
            full_q  <= 1'b0;
            fidx_q  <= '0;
            fpend_q <= 1'b0;
            valid_q <= '0;
            dirty_q <= '0;
            for (int s = 0; s < SETS; s++) vptr_q[s] <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            vway_q  <= vway_d;
            vset_q  <= vset_d;
            vtag_q  <= vtag_d;
            full_q  <= full_d;
            fidx_q  <= fidx_d;
            fpend_q <= fpend_d;
            if (hit_wr) dirty_q[hit_line] <= 1'b1;
            if (wb_last) dirty_q[cur_line] <= 1'b0;
            if (scan_inv) valid_q[fidx_q] <= 1'b0;
            if (fill_last) begin
                valid_q[cur_line] <= 1'b1;
                dirty_q[cur_line] <= 1'b0;
                if (full_q)
                    vptr_q[vset_q] <= (vptr_q[vset_q] == WAY_W'(WAYS - 1)) ? '0 : vptr_q[vset_q] + WAY_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (hit_wr) begin
            for (int b = 0; b < 8; b++)
                if (dreq_strobe_i[b]) mem_q[hit_idx][b*8 +: 8] <= dreq_data_i[b*8 +: 8];
        end
        if (fill_wr) mem_q[burst_idx] <= cresp_data_i;
        if (fill_last) tag_q[cur_line] <= vtag_q;
    end

    assign mem_o = mem_q;

endmodule

// File: tb/tb_dcache_assoc.sv
// tb/tb_dcache_assoc.sv - scoreboard bench for dcache_assoc (2 ways, 8 sets, 16-word lines)
// Backing memory word at address a defaults to {~a, a}.
module tb_dcache_assoc;
    logic        clk = 1'b0;
    logic        reset;
    logic        dreq_valid;
    logic [31:0] dreq_addr;
    logic [2:0]  dreq_size;
    logic [7:0]  dreq_strobe;
    logic [63:0] dreq_data;
    logic        dresp_addr_ok, dresp_data_ok;
    logic [63:0] dresp_data;
    logic        creq_valid, creq_is_write;
    logic [31:0] creq_addr;
    logic [2:0]  creq_size;
    logic [3:0]  creq_len;
    logic [1:0]  creq_burst;
    logic [7:0]  creq_strobe;
    logic [63:0] creq_data;
    logic        cresp_ready, cresp_last;
    logic [63:0] cresp_data;
    logic        flush_req, flush_done;
    logic [63:0] mem_w [2*8*16];

    dcache_assoc #(.WAYS(2), .SETS(8), .LINE_WORDS(16)) dut (
        .clk(clk), .reset(reset),
        .dreq_valid_i(dreq_valid), .dreq_addr_i(dreq_addr), .dreq_size_i(dreq_size),
        .dreq_strobe_i(dreq_strobe), .dreq_data_i(dreq_data),
        .dresp_addr_ok_o(dresp_addr_ok), .dresp_data_ok_o(dresp_data_ok), .dresp_data_o(dresp_data),
        .creq_valid_o(creq_valid), .creq_is_write_o(creq_is_write), .creq_addr_o(creq_addr),
        .creq_size_o(creq_size), .creq_len_o(creq_len), .creq_burst_o(creq_burst),
        .creq_strobe_o(creq_strobe), .creq_data_o(creq_data),
        .cresp_ready_i(cresp_ready), .cresp_last_i(cresp_last), .cresp_data_i(cresp_data),
        .flush_req_i(flush_req), .flush_done_o(flush_done), .mem_o(mem_w)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;

    logic [63:0] exp_d_q [$];
    bit          exp_c_q [$];
    logic [32:0] exp_b_q [$];

    logic [63:0] bmem [logic [31:0]];
    int          rsp_beat;
    bit          in_burst;
    bit          stall_en = 1'b0;

    function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endfunction

    function automatic logic [63:0] rd_mem(input logic [31:0] a);
        if (bmem.exists(a)) return bmem[a];
        return {~a, a};
    endfunction

    // cbus memory: one beat per ready, optional random stalls, checks burst order and fields
    initial begin : responder
        logic [31:0] b_addr, a;
        logic        b_wr;
        logic [32:0] eb;
        int          stall_left;
        cresp_ready = 1'b0;
        cresp_last  = 1'b0;
        cresp_data  = '0;
        rsp_beat    = 0;
        in_burst    = 1'b0;
        stall_left  = 0;
        b_addr      = '0;
        b_wr        = 1'b0;
        forever begin
            @(negedge clk);
            if (cresp_ready) begin
                if (cresp_last) begin
                    in_burst = 1'b0;
                    rsp_beat = 0;
                end else begin
                    rsp_beat++;
                end
            end
            cresp_ready = 1'b0;
            cresp_last  = 1'b0;
            if (reset || !creq_valid) begin
                in_burst   = 1'b0;
                rsp_beat   = 0;
                stall_left = 0;
            end else begin
                if (!in_burst) begin
                    in_burst = 1'b1;
                    b_addr   = creq_addr;
                    b_wr     = creq_is_write;
                    if (exp_b_q.size() == 0) begin
                        chk("unexpected_burst", {31'd0, creq_valid}, 64'd0);
                    end else begin
                        eb = exp_b_q.pop_front();
                        chk("burst_dir_addr", {31'd0, creq_is_write, creq_addr}, {31'd0, eb});
                    end
                    chk("burst_fields", {creq_size, creq_len, creq_burst, creq_strobe},
                        {3'd3, 4'd15, 2'd1, b_wr ? 8'hFF : 8'h00});
                end
                if (stall_left > 0) begin
                    stall_left--;
                end else begin
                    a = b_addr + 32'(rsp_beat * 8);
                    if (b_wr) bmem[a] = creq_data;
                    cresp_data  = rd_mem(a);
                    cresp_ready = 1'b1;
                    cresp_last  = (rsp_beat == 15);
                    if (rsp_beat == 15)
                        chk("burst_stable", {31'd0, creq_is_write, creq_addr}, {31'd0, b_wr, b_addr});
                    stall_left = stall_en ? int'($urandom_range(3, 0)) : 0;
                end
            end
        end
    end

    initial begin : dresp_monitor
        logic [63:0] e;
        bit          c;
        forever begin
            @(negedge clk);
            if (!reset && dresp_data_ok) begin
                if (exp_d_q.size() == 0) begin
                    chk("unexpected_data_ok", {63'd0, dresp_data_ok}, 64'd0);
                end else begin
                    e = exp_d_q.pop_front();
                    c = exp_c_q.pop_front();
                    if (c) chk("dresp_data", dresp_data, e);
                end
            end
        end
    end

    task automatic access(input logic [31:0] a, input bit wr, input logic [63:0] d,
                          input logic [7:0] s, input logic [63:0] exp, input int exp_lat);
        int n;
        exp_d_q.push_back(exp);
        exp_c_q.push_back(!wr);
        dreq_valid  = 1'b1;
        dreq_addr   = a;
        dreq_size   = 3'd3;
        dreq_strobe = wr ? s : 8'h00;
        dreq_data   = d;
        n = 0;
        forever begin
            @(negedge clk);
            if (dresp_addr_ok) break;
            n++;
            if (n > 300) break;
        end
        if (n > 300) chk("addr_ok_timeout", {63'd0, dresp_addr_ok}, 64'd1);
        else if (exp_lat >= 0) chk("latency", 64'(n), 64'(exp_lat));
        @(posedge clk);
        #1;
        dreq_valid = 1'b0;
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin : stimulus
        int n;
        bit got;
        reset       = 1'b1;
        dreq_valid  = 1'b0;
        dreq_addr   = '0;
        dreq_size   = 3'd3;
        dreq_strobe = '0;
        dreq_data   = '0;
        flush_req   = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_addr_ok", {63'd0, dresp_addr_ok}, 64'd0);
        chk("reset_data_ok", {63'd0, dresp_data_ok}, 64'd0);
        chk("reset_creq_valid", {63'd0, creq_valid}, 64'd0);
        chk("reset_flush_done", {63'd0, flush_done}, 64'd0);
        #2 reset = 1'b0;
        @(posedge clk);
        #1;

        // cold miss, hit, partial write, merged read
        exp_b_q.push_back({1'b0, 32'h0000_1000});
        access(32'h1000, 0, '0, '0, 64'hFFFF_EFFF_0000_1000, 17);
        access(32'h1008, 0, '0, '0, 64'hFFFF_EFF7_0000_1008, 0);
        access(32'h1000, 1, 64'h0000_0000_DEAD_BEEF, 8'h0F, '0, 0);
        access(32'h1000, 0, '0, '0, 64'hFFFF_EFFF_DEAD_BEEF, 0);

        // same-set fills, dirty eviction of way0, then writeback data returns
        exp_b_q.push_back({1'b0, 32'h0000_2000});
        access(32'h2000, 0, '0, '0, 64'hFFFF_DFFF_0000_2000, 17);
        exp_b_q.push_back({1'b1, 32'h0000_1000});
        exp_b_q.push_back({1'b0, 32'h0000_3000});
        access(32'h3000, 0, '0, '0, 64'hFFFF_CFFF_0000_3000, 33);
        exp_b_q.push_back({1'b0, 32'h0000_1000});
        access(32'h1000, 0, '0, '0, 64'hFFFF_EFFF_DEAD_BEEF, 17);

        // three dirty lines, flush in scan order
        access(32'h1000, 1, 64'hCAFE_F00D_0000_0000, 8'hF0, '0, 0);
        exp_b_q.push_back({1'b0, 32'h0000_1080});
        access(32'h1088, 1, 64'h1111_2222_3333_4444, 8'hFF, '0, 17);
        exp_b_q.push_back({1'b0, 32'h0000_1100});
        access(32'h1100, 1, 64'h5555_6666_7777_8888, 8'hF0, '0, 17);
        exp_b_q.push_back({1'b1, 32'h0000_1080});
        exp_b_q.push_back({1'b1, 32'h0000_1100});
        exp_b_q.push_back({1'b1, 32'h0000_1000});
        flush_req = 1'b1;
        @(posedge clk);
        #1;
        flush_req = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (flush_done) begin
                got = 1'b1;
                break;
            end
        end
        chk("flush_done_seen", {63'd0, got}, 64'd1);
        @(negedge clk);
        chk("flush_done_pulse", {63'd0, flush_done}, 64'd0);
        chk("flush_bursts_left", 64'(exp_b_q.size()), 64'd0);
        @(posedge clk);
        #1;
        exp_b_q.push_back({1'b0, 32'h0000_1000});
        access(32'h1000, 0, '0, '0, 64'hCAFE_F00D_DEAD_BEEF, 17);
        exp_b_q.push_back({1'b0, 32'h0000_1100});
        access(32'h1100, 0, '0, '0, 64'h5555_6666_0000_1100, 17);
        exp_b_q.push_back({1'b0, 32'h0000_1080});
        access(32'h1088, 0, '0, '0, 64'h1111_2222_3333_4444, 17);

        // async reset in the middle of a fetch
        exp_b_q.push_back({1'b0, 32'h0000_5180});
        dreq_valid = 1'b1;
        dreq_addr  = 32'h5180;
        n = 0;
        while (!(in_burst && rsp_beat == 5) && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("reached_beat5", 64'(rsp_beat), 64'd5);
        #2 reset = 1'b1;
        #1;
        chk("reset_mid_burst_creq_valid", {63'd0, creq_valid}, 64'd0);
        dreq_valid = 1'b0;
        @(negedge clk);
        #2 reset = 1'b0;
        @(posedge clk);
        #1;
        exp_b_q.push_back({1'b0, 32'h0000_5180});
        access(32'h5180, 0, '0, '0, 64'hFFFF_AE7F_0000_5180, 17);

        // stalled bursts: same data and final hits
        stall_en = 1'b1;
        exp_b_q.push_back({1'b0, 32'h0000_1000});
        access(32'h1010, 0, '0, '0, 64'hFFFF_EFEF_0000_1010, -1);
        access(32'h1078, 0, '0, '0, 64'hFFFF_EF87_0000_1078, 0);
        access(32'h1000, 0, '0, '0, 64'hCAFE_F00D_DEAD_BEEF, 0);
        access(32'h1040, 1, 64'h0123_4567_89AB_CDEF, 8'hFF, '0, 0);
        exp_b_q.push_back({1'b0, 32'h0000_2000});
        access(32'h2000, 0, '0, '0, 64'hFFFF_DFFF_0000_2000, -1);
        exp_b_q.push_back({1'b1, 32'h0000_1000});
        exp_b_q.push_back({1'b0, 32'h0000_3000});
        access(32'h3000, 0, '0, '0, 64'hFFFF_CFFF_0000_3000, -1);
        exp_b_q.push_back({1'b0, 32'h0000_1000});
        access(32'h1040, 0, '0, '0, 64'h0123_4567_89AB_CDEF, -1);
        access(32'h1040, 0, '0, '0, 64'h0123_4567_89AB_CDEF, 0);

        repeat (5) @(negedge clk);
        chk("bursts_outstanding", 64'(exp_b_q.size()), 64'd0);
        chk("dresp_outstanding", 64'(exp_d_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
